// File: rtl/switch_pkg.sv
// Shared constants, header layout and FSM encoding for the switch ingress path.
// Imported by the cell builder and its word packer.
package switch_pkg;

    localparam int CELL_BYTES = 64;
    localparam int WORD_BYTES = 16;
    localparam int IDX_W      = 12;
    localparam int CELL_LSB   = $clog2(CELL_BYTES);

    // Bit positions inside the 16-bit header {byte0, byte1}.
    localparam int HDR_LEN_HI_LSB = 12;
    localparam int HDR_PORT_LSB   = 8;
    localparam int HDR_LEN_LO_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PACK,
        ST_PAD,
        ST_DROP
    } state_e;

    function automatic logic [15:0] build_hdr(logic [IDX_W-1:0] tot, logic [3:0] port);
        logic [15:0] h;
        h = '0;
        h[HDR_LEN_HI_LSB +: 4] = tot[11:8];
        h[HDR_PORT_LSB   +: 4] = port;
        h[HDR_LEN_LO_LSB +: 8] = tot[7:0];
        return h;
    endfunction

    function automatic logic [IDX_W-1:0] pad_len(logic [IDX_W-1:0] tot);
        return (tot + IDX_W'(CELL_BYTES - 1)) & ~IDX_W'(CELL_BYTES - 1);
    endfunction

endpackage

// File: rtl/switch_pre_if.sv
// Ingress FIFO read side plus core cell-FIFO write side of the cell builder.
// The master modport is the builder; the slave modport is the surrounding FIFOs.
interface switch_pre_if;

    logic         ptr_fifo_empty;
    logic [15:0]  ptr_fifo_dout;
    logic         ptr_fifo_rd;
    logic         data_fifo_empty;
    logic [7:0]   data_fifo_dout;
    logic         data_fifo_rd;
    logic         i_cell_bp;
    logic         i_cell_data_fifo_wr;
    logic [127:0] i_cell_data_fifo_din;
    logic         i_cell_data_first;
    logic         i_cell_data_last;

    modport master (
        input  ptr_fifo_empty, ptr_fifo_dout, data_fifo_empty, data_fifo_dout, i_cell_bp,
        output ptr_fifo_rd, data_fifo_rd, i_cell_data_fifo_wr, i_cell_data_fifo_din,
               i_cell_data_first, i_cell_data_last
    );

    modport slave (
        output ptr_fifo_empty, ptr_fifo_dout, data_fifo_empty, data_fifo_dout, i_cell_bp,
        input  ptr_fifo_rd, data_fifo_rd, i_cell_data_fifo_wr, i_cell_data_fifo_din,
               i_cell_data_first, i_cell_data_last
    );

endinterface

// File: rtl/cell_packer_b8_w128.sv
// Shifts bytes into a 128-bit word (byte 0 ends up in the MSBs) and emits the
// completed word one cycle after its 16th byte, with first/last flags.
module cell_packer_b8_w128
    import switch_pkg::*;
(
    input  logic         clk,
    input  logic         rstn,
    input  logic         start_i,
    input  logic [15:0]  hdr_i,
    input  logic         place_i,
    input  logic [7:0]   byte_i,
    input  logic         last_i,
    output logic         wr_o,
    output logic [127:0] data_o,
    output logic         first_o,
    output logic         last_o
);

    localparam int WORD_W = WORD_BYTES * 8;

    logic [WORD_W-9:0] shift_q;
    logic [3:0]        idx_q;
    logic              first_pend_q;
    logic              wr_q;
    logic [WORD_W-1:0] data_q;
    logic              first_q;
    logic              last_q;
    logic              word_done;

    assign word_done = place_i && (idx_q == 4'(WORD_BYTES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_q      <= '0;
            idx_q        <= '0;
            first_pend_q <= 1'b0;
            wr_q         <= 1'b0;
            data_q       <= '0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            wr_q <= word_done;
            if (start_i) begin
                shift_q      <= {shift_q[WORD_W-25:0], hdr_i};
                idx_q        <= 4'd2;
                first_pend_q <= 1'b1;
            end else if (place_i) begin
                shift_q <= {shift_q[WORD_W-17:0], byte_i};
                idx_q   <= idx_q + 4'd1;
            end
            if (word_done) begin
                data_q       <= {shift_q, byte_i};
                first_q      <= first_pend_q;
                last_q       <= last_i;
                first_pend_q <= 1'b0;
            end
        end
    end

    assign wr_o    = wr_q;
    assign data_o  = data_q;
    assign first_o = first_q;
    assign last_o  = last_q;

endmodule

// File: rtl/switch_pre.sv
// Ingress cell builder: pops one frame, prepends a length/port header, pads to a
// 64-byte cell boundary and writes 128-bit words, honoring backpressure per cell.
module switch_pre
    import switch_pkg::*;
#(
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1518
) (
    input  logic         clk,
    input  logic         rstn,
    switch_pre_if.master bus
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] pad_q, pad_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [IDX_W-1:0] pay_cnt_q, pay_cnt_d;

    logic [IDX_W-1:0] len_in;
    logic [IDX_W-1:0] tot_in;
    logic [IDX_W-1:0] idx_next;
    logic             len_ok;
    logic             cell_stall;
    logic             ptr_rd;
    logic             data_rd;
    logic             pk_start;
    logic [15:0]      pk_hdr;
    logic             pk_place;
    logic [7:0]       pk_byte;
    logic             pk_last;

    assign len_in   = bus.ptr_fifo_dout[11:0];
    assign tot_in   = len_in + 12'd2;
    assign len_ok   = (len_in >= 12'(MIN_LEN)) && (len_in <= 12'(MAX_LEN));
    assign pk_hdr   = build_hdr(tot_in, bus.ptr_fifo_dout[15:12]);
    assign idx_next = byte_idx_q + 12'd1;

    // A finished cell may not be followed by another while the core is almost full.
    assign cell_stall = (byte_idx_q[CELL_LSB-1:0] == '0) && (byte_idx_q != '0) && bus.i_cell_bp;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        len_d      = len_q;
        pad_d      = pad_q;
        byte_idx_d = byte_idx_q;
        pay_cnt_d  = pay_cnt_q;
        ptr_rd     = 1'b0;
        data_rd    = 1'b0;
        pk_start   = 1'b0;
        pk_place   = 1'b0;
        pk_byte    = 8'h00;
        pk_last    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!bus.ptr_fifo_empty && !bus.i_cell_bp) state_d = ST_HDR;
            end
            ST_HDR: begin
                ptr_rd     = 1'b1;
                pk_start   = 1'b1;
                len_d      = len_in;
                pad_d      = pad_len(tot_in);
                byte_idx_d = 12'd2;
                pay_cnt_d  = '0;
                state_d    = len_ok ? ST_PACK : ST_DROP;
            end
            ST_PACK: begin
                if (!bus.data_fifo_empty && !cell_stall) begin
                    data_rd    = 1'b1;
                    pk_place   = 1'b1;
                    pk_byte    = bus.data_fifo_dout;
                    byte_idx_d = idx_next;
                    pay_cnt_d  = pay_cnt_q + 12'd1;
                    if (pay_cnt_q == len_q - 12'd1) begin
                        if (idx_next == pad_q) begin
                            pk_last = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_PAD;
                        end
                    end
                end
            end
            ST_PAD: begin
                if (!cell_stall) begin
                    pk_place   = 1'b1;
                    byte_idx_d = idx_next;
                    if (idx_next == pad_q) begin
                        pk_last = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (pay_cnt_q == len_q) begin
                    state_d = ST_IDLE;
                end else if (!bus.data_fifo_empty) begin
                    data_rd   = 1'b1;
                    pay_cnt_d = pay_cnt_q + 12'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            pad_q      <= '0;
            byte_idx_q <= '0;
            pay_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            pad_q      <= pad_d;
            byte_idx_q <= byte_idx_d;
            pay_cnt_q  <= pay_cnt_d;
        end
    end

    assign bus.ptr_fifo_rd  = ptr_rd;
    assign bus.data_fifo_rd = data_rd;

    cell_packer_b8_w128 u_packer (
        .clk     (clk),
        .rstn    (rstn),
        .start_i (pk_start),
        .hdr_i   (pk_hdr),
        .place_i (pk_place),
        .byte_i  (pk_byte),
        .last_i  (pk_last),
        .wr_o    (bus.i_cell_data_fifo_wr),
        .data_o  (bus.i_cell_data_fifo_din),
        .first_o (bus.i_cell_data_first),
        .last_o  (bus.i_cell_data_last)
    );

endmodule

// File: tb/tb_switch_pre.sv
// Directed bench for switch_pre: FWFT FIFO models feed frames, a negedge monitor
// captures cell words, and each frame is compared against a header/pad model.
module tb_switch_pre;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    switch_pre_if bus ();

    switch_pre #(.MIN_LEN(60), .MAX_LEN(1518)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] din;
        logic [1:0]   fl;
        int           cyc;
    } word_t;

    word_t        cap[$];
    logic [15:0]  pq[$];
    logic [7:0]   dq[$];
    int           drd[$];
    int           ppop[$];
    logic [127:0] exp_w[$];

    int cyc     = 0;
    int t_vis   = 0;
    int vis_cnt = 0;
    int total   = 0;
    int bad     = 0;
    int viol    = 0;
    bit hold_on   = 1'b0;
    bit ptr_rd_s  = 1'b0;
    bit data_rd_s = 1'b0;
    bit prev_pe   = 1'b1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // FWFT FIFO models: pops land just after the edge that consumed the entry.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (ptr_rd_s && pq.size() > 0) void'(pq.pop_front());
        if (data_rd_s && dq.size() > 0) void'(dq.pop_front());
        bus.ptr_fifo_empty  = (pq.size() == 0);
        bus.ptr_fifo_dout   = (pq.size() > 0) ? pq[0] : 16'h0000;
        bus.data_fifo_empty = (dq.size() == 0) ||
                              (hold_on && cyc >= t_vis + 13 && cyc < t_vis + 18);
        bus.data_fifo_dout  = (dq.size() > 0) ? dq[0] : 8'h00;
        if (prev_pe && !bus.ptr_fifo_empty) begin
            t_vis = cyc;
            vis_cnt++;
        end
        prev_pe = bus.ptr_fifo_empty;
    end

    always @(negedge clk) begin
        ptr_rd_s  = bus.ptr_fifo_rd;
        data_rd_s = bus.data_fifo_rd;
        if (bus.i_cell_data_fifo_wr)
            cap.push_back('{bus.i_cell_data_fifo_din,
                            {bus.i_cell_data_first, bus.i_cell_data_last}, cyc});
        if (bus.ptr_fifo_rd) begin
            ppop.push_back(cyc);
            if (bus.ptr_fifo_empty) viol++;
        end
        if (bus.data_fifo_rd) begin
            drd.push_back(cyc);
            if (bus.data_fifo_empty) viol++;
        end
    end

    function automatic logic [7:0] pay_byte(int seed, int k);
        int v;
        v = seed + 7 * k + k / 37;
        return v[7:0];
    endfunction

    function automatic int drd_in(int lo, int hi);
        int n;
        n = 0;
        foreach (drd[i]) if (drd[i] >= lo && drd[i] < hi) n++;
        return n;
    endfunction

    task automatic start_test();
        cap.delete();
        drd.delete();
        ppop.delete();
    endtask

    task automatic load_frame(input logic [3:0] port, input int len, input int seed);
        for (int k = 0; k < len; k++) dq.push_back(pay_byte(seed, k));
        pq.push_back({port, 12'(len)});
    endtask

    task automatic build_expect(input logic [3:0] port, input int len, input int seed);
        logic [11:0]  tot;
        logic [7:0]   b;
        logic [127:0] w;
        int           pad;
        exp_w.delete();
        tot = 12'(len + 2);
        pad = ((len + 2 + 63) / 64) * 64;
        w   = '0;
        for (int i = 0; i < pad; i++) begin
            if (i == 0)            b = {tot[11:8], port};
            else if (i == 1)       b = tot[7:0];
            else if (i < len + 2)  b = pay_byte(seed, i - 2);
            else                   b = 8'h00;
            w = {w[119:0], b};
            if (i % 16 == 15) exp_w.push_back(w);
        end
    endtask

    task automatic check_frame(input string tag, input logic [3:0] port, input int len,
                               input int seed);
        int n;
        build_expect(port, len, seed);
        n = exp_w.size();
        check({tag, "_nwords"}, 128'(cap.size()), 128'(n));
        for (int i = 0; i < n && i < cap.size(); i++) begin
            check($sformatf("%s_w%0d_din", tag, i), cap[i].din, exp_w[i]);
            check($sformatf("%s_w%0d_fl", tag, i), 128'(cap[i].fl), 128'({i == 0, i == n - 1}));
        end
    endtask

    task automatic wait_words(input string tag, input int n, input int budget);
        int c;
        c = 0;
        while (cap.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        if (cap.size() < n) check({tag, "_timeout"}, 128'(cap.size()), 128'(n));
        repeat (4) @(posedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ptr_rd"}, 128'(bus.ptr_fifo_rd), 128'(0));
        check({tag, "_data_rd"}, 128'(bus.data_fifo_rd), 128'(0));
        check({tag, "_wr"}, 128'(bus.i_cell_data_fifo_wr), 128'(0));
        check({tag, "_din"}, bus.i_cell_data_fifo_din, 128'(0));
        check({tag, "_first"}, 128'(bus.i_cell_data_first), 128'(0));
        check({tag, "_last"}, 128'(bus.i_cell_data_last), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int v0;
        int c;
        bus.i_cell_bp = 1'b0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_outputs_zero("reset");
        @(negedge clk) rstn = 1'b1;
        repeat (3) @(posedge clk);

        // 60-byte frame, port 3: tot 62 -> one cell, header 0x03 0x3E.
        start_test();
        load_frame(4'd3, 60, 16);
        wait_words("t1", 4, 300);
        check_frame("t1", 4'd3, 60, 16);
        check("t1_hdr", 128'(cap[0].din[127:112]), 128'(16'h033E));
        check("t1_ptr_rd_cyc", 128'(ppop[0] - t_vis), 128'(1));
        check("t1_ptr_pops", 128'(ppop.size()), 128'(1));
        check("t1_first_wr_cyc", 128'(cap[0].cyc - t_vis), 128'(16));
        check("t1_last_wr_cyc", 128'(cap[3].cyc - t_vis), 128'(64));
        check("t1_pad_zero", 128'(cap[3].din[15:0]), 128'(0));
        check("t1_drained", 128'(dq.size()), 128'(0));

        // 1518-byte frame, port 5: tot 1520 = 0x5F0, pad 1536, 96 words.
        start_test();
        load_frame(4'd5, 1518, 33);
        wait_words("t2", 96, 2500);
        check_frame("t2", 4'd5, 1518, 33);
        check("t2_hdr", 128'(cap[0].din[127:112]), 128'(16'h55F0));
        check("t2_pad_word", cap[95].din, 128'(0));
        check("t2_last_wr_cyc", 128'(cap[95].cyc - t_vis), 128'(1536));
        check("t2_drained", 128'(dq.size()), 128'(0));

        // Backpressure for 20 cycles once the byte index reaches 64.
        start_test();
        v0 = vis_cnt;
        load_frame(4'd1, 200, 64);
        c = 0;
        do begin
            @(posedge clk);
            #2;
            c++;
        end while (!(vis_cnt != v0 && cyc == t_vis + 64) && c < 400);
        check("t3_reach_64", 128'(vis_cnt != v0 && cyc == t_vis + 64), 128'(1));
        bus.i_cell_bp = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        bus.i_cell_bp = 1'b0;
        wait_words("t3", 16, 600);
        check_frame("t3", 4'd1, 200, 64);
        check("t3_no_rd_in_hold", 128'(drd_in(t_vis + 64, t_vis + 84)), 128'(0));
        c = 0;
        foreach (cap[i]) if (cap[i].cyc < t_vis + 84) c++;
        check("t3_words_before_resume", 128'(c), 128'(4));
        for (int i = 0; i < 16 && i < cap.size(); i++)
            check($sformatf("t3_wr_cyc%0d", i), 128'(cap[i].cyc - t_vis),
                  128'(16 * (i + 1) + ((i < 4) ? 0 : 20)));

        // Data underrun for 5 cycles after payload byte 10.
        start_test();
        hold_on = 1'b1;
        load_frame(4'd2, 60, 119);
        wait_words("t4", 4, 300);
        hold_on = 1'b0;
        check_frame("t4", 4'd2, 60, 119);
        check("t4_no_rd_in_gap", 128'(drd_in(t_vis + 13, t_vis + 18)), 128'(0));
        check("t4_byte10_cyc", 128'(drd[10] - t_vis), 128'(12));
        check("t4_byte11_cyc", 128'(drd[11] - t_vis), 128'(18));
        check("t4_first_wr_cyc", 128'(cap[0].cyc - t_vis), 128'(21));
        check("t4_last_wr_cyc", 128'(cap[3].cyc - t_vis), 128'(69));

        // Length 40 is dropped, the following 64-byte frame (tot 66) gives 8 words.
        start_test();
        load_frame(4'd4, 40, 85);
        load_frame(4'd6, 64, 144);
        wait_words("t5", 8, 600);
        check_frame("t5", 4'd6, 64, 144);
        check("t5_hdr", 128'(cap[0].din[127:112]), 128'(16'h0642));
        check("t5_ptr_pops", 128'(ppop.size()), 128'(2));
        check("t5_data_pops", 128'(drd.size()), 128'(104));
        check("t5_no_wr_in_drop", 128'(cap[0].cyc > ppop[1]), 128'(1));
        check("t5_drained", 128'(dq.size()), 128'(0));

        // Reset after word 2 of a long frame, then a clean 60-byte frame.
        start_test();
        load_frame(4'd5, 1518, 51);
        c = 0;
        while (cap.size() < 3 && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("t6_three_words", 128'(cap.size() >= 3), 128'(1));
        #1;
        rstn = 1'b0;
        #1;
        check_outputs_zero("t6_rst");
        pq.delete();
        dq.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        repeat (3) @(posedge clk);
        start_test();
        load_frame(4'd7, 60, 5);
        wait_words("t6", 4, 300);
        check_frame("t6", 4'd7, 60, 5);
        check("t6_ptr_pops", 128'(ppop.size()), 128'(1));
        check("t6_last_wr_cyc", 128'(cap[3].cyc - t_vis), 128'(64));

        check("fifo_rd_when_empty", 128'(viol), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
